// File: rtl/ysyx22041405_pc_fetch.sv
// ysyx22041405_pc_fetch: PC register and single-issue instruction fetch stage.
// Holds the pc, fetches one instruction over a valid/ready request plus
// valid-only response interface, and presents {pc, pc_add4, inst} to decode.
// Optional feature macro: YSYX22041405_FETCH_MISALIGN_EN. When it is defined,
// a misaligned branch target parks the stage in a terminal error state.
module ysyx22041405_pc_fetch #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] next_pc,
  input  logic             next_pc_valid,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_add4,
  output logic             fetch_misalign
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT     = 3'd2,
    S_HOLD     = 3'd3,
    S_WAIT_NPC = 3'd4,
    S_ERR      = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
`ifdef YSYX22041405_FETCH_MISALIGN_EN
  logic             misalign_q, misalign_d;
`endif

  // Next-state logic; pc and inst are written only on their consuming transitions.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
`ifdef YSYX22041405_FETCH_MISALIGN_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        // A response arriving in the same cycle as acceptance is not ours yet.
        if (imem_req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          state_d = S_WAIT_NPC;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_WAIT_NPC: begin
        if (next_pc_valid) begin
          pc_d = next_pc;
`ifdef YSYX22041405_FETCH_MISALIGN_EN
          if (next_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = S_ERR;
          end else begin
            state_d    = S_REQ;
          end
`else
          state_d = S_REQ;
`endif
        end else begin
          state_d = S_WAIT_NPC;
        end
      end
      S_ERR: begin
`ifdef YSYX22041405_FETCH_MISALIGN_EN
        // Terminal until reset: no further fetches after a bad target.
        state_d = S_ERR;
`else
        // Unreachable without the error feature; recover defensively.
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pc and instruction registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

`ifdef YSYX22041405_FETCH_MISALIGN_EN
  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
  assign fetch_misalign = misalign_q;
`else
  assign fetch_misalign = 1'b0;
`endif

  // Moore outputs decoded straight from registered state.
  assign imem_req_valid = (state_q == S_REQ);
  assign inst_valid     = (state_q == S_HOLD);
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign pc_add4        = pc_q + WIDTH'(4);
  assign inst           = inst_q;

endmodule

// File: tb/tb_ysyx22041405_pc_fetch.sv
// Directed self-checking bench for ysyx22041405_pc_fetch.
module tb_ysyx22041405_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        next_pc_valid;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_add4;
  logic        fetch_misalign;

  int checks;
  int failures;
  int cyc;
  int hs_cnt;
  int last_hs;
  int hs_gap;
  int hs_before;

  ysyx22041405_pc_fetch #(
    .WIDTH   (32),
    .RESET_PC(32'h8000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .next_pc       (next_pc),
    .next_pc_valid (next_pc_valid),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .pc            (pc),
    .pc_add4       (pc_add4),
    .fetch_misalign(fetch_misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter and request-handshake monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_req_valid && imem_req_ready) begin
      hs_cnt  <= hs_cnt + 1;
      hs_gap  <= cyc - last_hs;
      last_hs <= cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From REQ: handshake, return one word, let decode take it; ends in WAIT_NPC.
  task automatic fetch_one(input logic [31:0] word, input logic [31:0] exp_pc);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    step();
    imem_rsp_valid = 1'b0;
    check_val("fetch_inst_valid", {31'd0, inst_valid}, 32'd1);
    check_val("fetch_inst", inst, word);
    check_val("fetch_pc", pc, exp_pc);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; hs_cnt = 0; last_hs = 0; hs_gap = 0;
    rst_n = 1'b1;
    next_pc = 32'h0; next_pc_valid = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    inst_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    // Reset values
    check_val("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_val("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check_val("rst_pc", pc, 32'h8000_0000);
    check_val("rst_inst", inst, 32'h0);
    check_val("rst_misalign", {31'd0, fetch_misalign}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();  // IDLE -> REQ
    check_val("req_valid", {31'd0, imem_req_valid}, 32'd1);
    check_val("req_addr", imem_addr, 32'h8000_0000);

    // Request backpressure with a spurious response in REQ
    hs_before = hs_cnt;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("bp_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check_val("bp_req_addr", imem_addr, 32'h8000_0000);
      check_val("bp_inst", inst, 32'h0);
    end
    // Same-cycle ready + rsp: response must be dropped
    imem_req_ready = 1'b1;
    imem_rsp_data  = 32'hBAD0_0001;
    step();  // -> WAIT
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    check_val("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_val("same_cyc_rsp_inst", inst, 32'h0);
    check_val("single_handshake", hs_cnt, hs_before + 1);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0413;
    step();  // -> HOLD
    imem_rsp_valid = 1'b0;
    check_val("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
    check_val("hold_inst", inst, 32'h0000_0413);
    check_val("hold_pc_add4", pc_add4, 32'h8000_0004);

    // Decode backpressure with a spurious next_pc_valid in HOLD
    next_pc = 32'h1234_5678;
    next_pc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("dbp_inst_valid", {31'd0, inst_valid}, 32'd1);
      check_val("dbp_inst", inst, 32'h0000_0413);
      check_val("dbp_pc", pc, 32'h8000_0000);
    end
    next_pc_valid = 1'b0;
    inst_ready = 1'b1;
    step();  // -> WAIT_NPC
    inst_ready = 1'b0;
    check_val("npc_inst_valid", {31'd0, inst_valid}, 32'd0);
    check_val("npc_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_val("npc_pc_unchanged", pc, 32'h8000_0000);
    next_pc = 32'h8000_0004;
    next_pc_valid = 1'b1;
    step();  // -> REQ
    next_pc_valid = 1'b0;
    check_val("seq_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check_val("seq_addr", imem_addr, 32'h8000_0004);

    // Zero-wait loop: everything always ready
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    inst_ready     = 1'b1;
    next_pc_valid  = 1'b1;
    next_pc        = 32'h8000_0008;
    step();  // WAIT
    step();  // HOLD
    check_val("zw_inst", inst, 32'h0000_0013);
    check_val("zw_pc", pc, 32'h8000_0004);
    step();  // WAIT_NPC
    step();  // REQ
    check_val("zw_addr", imem_addr, 32'h8000_0008);
    step();  // WAIT
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
    next_pc_valid  = 1'b0;
    check_val("zw_gap", hs_gap, 32'd4);

    // Asynchronous reset while in WAIT
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_val("arst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check_val("arst_pc", pc, 32'h8000_0000);
    check_val("arst_inst", inst, 32'h0);
    @(negedge clk);
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    rst_n = 1'b1;
    step();  // IDLE -> REQ, late response dropped
    check_val("late_addr", imem_addr, 32'h8000_0000);
    check_val("late_inst_idle", inst, 32'h0);
    step();  // still REQ, response still ignored
    imem_rsp_valid = 1'b0;
    check_val("late_inst_req", inst, 32'h0);
    check_val("late_req_valid", {31'd0, imem_req_valid}, 32'd1);
    fetch_one(32'h0010_0093, 32'h8000_0000);

    // Misaligned branch target
    next_pc = 32'h8000_0006;
    next_pc_valid = 1'b1;
    step();
    next_pc_valid = 1'b0;
`ifdef YSYX22041405_FETCH_MISALIGN_EN
    check_val("mis_flag", {31'd0, fetch_misalign}, 32'd1);
    check_val("mis_pc", pc, 32'h8000_0006);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
      check_val("mis_no_inst", {31'd0, inst_valid}, 32'd0);
      check_val("mis_sticky", {31'd0, fetch_misalign}, 32'd1);
      step();
    end
    imem_req_ready = 1'b0;
`else
    check_val("mis_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check_val("mis_addr", imem_addr, 32'h8000_0006);
    check_val("mis_flag_off", {31'd0, fetch_misalign}, 32'd0);
`endif

    // Wrap of pc_add4
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();  // REQ
    fetch_one(32'h0000_0537, 32'h8000_0000);
    next_pc = 32'hFFFF_FFFC;
    next_pc_valid = 1'b1;
    step();  // REQ at wrap address
    next_pc_valid = 1'b0;
    check_val("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check_val("wrap_pc_add4", pc_add4, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
